// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS fetch stage: holds the PC, forms the
// branch/jump/register targets and parks a redirect that arrives during a stall.
module pc_sequencer #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          OFF_W    = 16,
    parameter int unsigned          J_W      = 26,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_sel,
    input  logic [ADDR_W-1:0] branch_base,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic [ADDR_W-1:0] jump_base,
    input  logic [J_W-1:0]    jump_field,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect_pending,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        SEL_NONE   = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_REG    = 2'b11
    } sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pend_target_q;
    logic              misaligned_q;

    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] reg_target_al;
    logic [ADDR_W-1:0] new_target;
    logic              redirect_active;
    logic              misaligned_d;
    sel_e              sel;

    // Low bits of jump_base are replaced by the jump field and never consulted.
    logic unused_jump_low;
    assign unused_jump_low = ^jump_base[J_W+1:0];

    assign sel             = sel_e'(redirect_sel);
    assign redirect_active = redirect_valid && (sel != SEL_NONE);

    assign off_ext       = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign branch_target = branch_base + (off_ext << 2);
    assign jump_target   = {jump_base[ADDR_W-1:J_W+2], jump_field, 2'b00};
    assign reg_target_al = {reg_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        new_target = branch_target;
        unique case (sel)
            SEL_BRANCH: new_target = branch_target;
            SEL_JUMP:   new_target = jump_target;
            SEL_REG:    new_target = reg_target_al;
            default:    new_target = branch_target;
        endcase
    end

    // A misaligned jr is flagged whether it lands in pc or in the pending slot.
    assign misaligned_d = redirect_active && (sel == SEL_REG) && (reg_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (stall && redirect_active) ? HELD : IDLE;
            HELD:    state_d = stall ? HELD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        redirect_pending = (state_q == HELD);
    end

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (redirect_active) begin
                pc_d = new_target;
            end else if (state_q == HELD) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            if (stall && redirect_active) begin
                pend_target_q <= new_target;
            end
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + ADDR_W'(4);
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan checks with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RST = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] branch_base, jump_base, reg_target;
    logic [15:0] branch_off;
    logic [25:0] jump_field;
    logic [31:0] pc, pc_plus4;
    logic        redirect_pending, misaligned;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pt;
    logic        m_pv, m_mis;
    bit          m_valid = 1'b0;

    pc_sequencer #(.ADDR_W(32), .OFF_W(16), .J_W(26), .RESET_PC(RST)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .branch_base(branch_base), .branch_off(branch_off),
        .jump_base(jump_base), .jump_field(jump_field), .reg_target(reg_target),
        .pc(pc), .pc_plus4(pc_plus4),
        .redirect_pending(redirect_pending), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] target_of(input logic [1:0] s);
        logic [31:0] t;
        case (s)
            2'd1:    t = branch_base + 32'(int'($signed(branch_off)) * 4);
            2'd2:    t = (jump_base & 32'hF000_0000) | (32'(jump_field) * 4);
            default: t = reg_target & ~32'd3;
        endcase
        return t;
    endfunction

    always @(posedge clk) begin
        logic        act;
        logic [31:0] t;
        if (reset) begin
            m_pc = RST; m_pv = 1'b0; m_pt = '0; m_mis = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            act   = redirect_valid && (redirect_sel != 2'd0);
            t     = target_of(redirect_sel);
            m_mis = act && (redirect_sel == 2'd3) && (reg_target % 4 != 0);
            if (stall) begin
                if (act) begin m_pv = 1'b1; m_pt = t; end
            end else begin
                m_pc = act ? t : (m_pv ? m_pt : m_pc + 32'd4);
                m_pv = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc",       pc,                       m_pc);
            check("model_pc_plus4", pc_plus4,                 m_pc + 32'd4);
            check("model_pending",  32'(redirect_pending),    32'(m_pv));
            check("model_misalign", 32'(misaligned),          32'(m_mis));
        end
    end

    task automatic cyc(input logic r, input logic s, input logic v, input logic [1:0] sel);
        @(negedge clk);
        reset = r; stall = s; redirect_valid = v; redirect_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic s, input logic [31:0] base, input logic [15:0] off);
        branch_base = base; branch_off = off;
        cyc(1'b0, s, 1'b1, 2'd1);
    endtask

    task automatic jmp(input logic s, input logic [31:0] base, input logic [25:0] f);
        jump_base = base; jump_field = f;
        cyc(1'b0, s, 1'b1, 2'd2);
    endtask

    task automatic jr(input logic s, input logic [31:0] t);
        reg_target = t;
        cyc(1'b0, s, 1'b1, 2'd3);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_sel = 2'd0;
        branch_base = '0; branch_off = '0; jump_base = '0; jump_field = '0; reg_target = '0;

        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        check("reset_pc", pc, 32'h0040_0000);
        check("reset_pc_plus4", pc_plus4, 32'h0040_0004);
        check("reset_pending", 32'(redirect_pending), 32'd0);
        check("reset_misaligned", 32'(misaligned), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0); check("seq1", pc, 32'h0040_0004);
        cyc(1'b0, 1'b0, 1'b0, 2'd0); check("seq2", pc, 32'h0040_0008);
        cyc(1'b0, 1'b0, 1'b0, 2'd0); check("seq3", pc, 32'h0040_000C);
        check("seq_pending", 32'(redirect_pending), 32'd0);

        br(1'b0, 32'h0040_0010, 16'hFFFE); check("branch_neg", pc, 32'h0040_0008);
        br(1'b0, 32'h0040_0010, 16'h0003); check("branch_pos", pc, 32'h0040_001C);
        jmp(1'b0, 32'h9000_0004, 26'h000_0100); check("jump", pc, 32'h9000_0400);
        jr(1'b0, 32'h0040_1003); check("jr_pc", pc, 32'h0040_1000);
        check("jr_misaligned", 32'(misaligned), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        check("misaligned_pulse_end", 32'(misaligned), 32'd0);
        check("after_jr", pc, 32'h0040_1004);

        // sel=00 with valid is ignored
        cyc(1'b0, 1'b0, 1'b1, 2'd0); check("sel00_ignored", pc, 32'h0040_1008);

        // stall three cycles: branch, jump, nothing
        br(1'b1, 32'h0040_00FC, 16'h0001);
        check("stall1_pc", pc, 32'h0040_1008);
        check("stall1_pending", 32'(redirect_pending), 32'd1);
        jmp(1'b1, 32'h0000_0000, 26'h010_0080);
        check("stall2_pc", pc, 32'h0040_1008);
        cyc(1'b0, 1'b1, 1'b0, 2'd0);
        check("stall3_pc", pc, 32'h0040_1008);
        check("stall3_pending", 32'(redirect_pending), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        check("unstall_pc", pc, 32'h0040_0200);
        check("unstall_pending", 32'(redirect_pending), 32'd0);

        // new redirect beats pending one
        br(1'b1, 32'h0040_00FC, 16'h0001);
        jr(1'b0, 32'h0040_0300);
        check("override_pc", pc, 32'h0040_0300);
        check("override_pending", 32'(redirect_pending), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0); check("override_discard", pc, 32'h0040_0304);

        // misaligned jr captured into the pending slot
        jr(1'b1, 32'h0040_0402);
        check("stalled_jr_misaligned", 32'(misaligned), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        check("stalled_jr_pc", pc, 32'h0040_0400);
        check("stalled_jr_mis_clear", 32'(misaligned), 32'd0);

        // reset during a held redirect, with a redirect in the reset cycle
        br(1'b1, 32'h0040_00FC, 16'h0001);
        jump_base = 32'h9000_0000; jump_field = 26'h3;
        cyc(1'b1, 1'b1, 1'b1, 2'd2);
        check("reset_mid_stall_pc", pc, 32'h0040_0000);
        check("reset_mid_stall_pending", 32'(redirect_pending), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0); check("post_reset_pc", pc, 32'h0040_0004);

        // wrap-around
        jr(1'b0, 32'hFFFF_FFFC); check("wrap_setup", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0000_0000);
        cyc(1'b0, 1'b0, 1'b0, 2'd0); check("wrap_pc", pc, 32'h0000_0000);
        br(1'b0, 32'hFFFF_FFF0, 16'h0008); check("branch_wrap", pc, 32'h0000_0010);

        for (int unsigned i = 0; i < 3000; i++) begin
            logic r, s, v;
            branch_base = $urandom; branch_off = 16'($urandom);
            jump_base   = $urandom; jump_field = 26'($urandom);
            reg_target  = $urandom;
            if ($urandom_range(0, 3) == 0) reg_target = 32'hFFFF_FFFC;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 2) == 0);
            v = ($urandom_range(0, 1) == 1);
            cyc(r, s, v, 2'($urandom));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
